ft245_sync_tx: RTL and testbench

Lossless transmit stage for the FT245 synchronous FIFO interface, clocked from the FTDI 60 MHz clock. Accepts bytes from an upstream producer (e.g. the counter/pattern generator) over a valid/ready handshake, buffers them in a small FIFO, and drives the FT245 write-side pins. A byte counts as transferred only on an edge where `write_n` is low and `tx_full` is low; a byte presented while `tx_full` is high is held and re-presented, so no bytes are dropped.

---
 rtl/ft245_pkg.sv | 27 ++
 rtl/ft245_byte_fifo.sv | 56 +++++
 rtl/ft245_sync_tx.sv | 122 ++++++++++++
 tb/tb_ft245_sync_tx.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft245_pkg.sv
// Shared constants and state encoding for the FT245 synchronous transmit stage.
// Optional build macro used by the top: FT245_SEND_IMMEDIATE_EN.
package ft245_pkg;

   localparam int unsigned FT245_BYTE_W      = 8;
   localparam int unsigned FT245_DEF_DEPTH   = 16;
   localparam int unsigned FT245_DEF_SI_IDLE = 64;

   typedef logic [1:0] ft245_state_t;

   localparam ft245_state_t ST_IDLE  = 2'd0;
   localparam ft245_state_t ST_SEND  = 2'd1;
   localparam ft245_state_t ST_STALL = 2'd2;
   localparam ft245_state_t ST_FLUSH = 2'd3;

   // The state is not stored; it is decoded from the output register, TXE# and the SIWU pulse.
   function automatic ft245_state_t ft245_state(input logic wr_n, input logic full,
                                                input logic flush);
      ft245_state_t st;
      if (flush)     st = ST_FLUSH;
      else if (wr_n) st = ST_IDLE;
      else if (full) st = ST_STALL;
      else           st = ST_SEND;
      return st;
   endfunction

endpackage

// File: rtl/ft245_byte_fifo.sv
// Byte FIFO with registered storage and a combinational head; pointers wrap modulo DEPTH.
module ft245_byte_fifo
   import ft245_pkg::*;
#(
   parameter int unsigned DEPTH = FT245_DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [FT245_BYTE_W-1:0]  push_data,
   input  logic                     pop,
   output logic [FT245_BYTE_W-1:0]  head,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     empty,
   output logic                     full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [FT245_BYTE_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [LVL_W-1:0]        count;
   logic                    do_push;
   logic                    do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign level = count;
   assign empty = (count == '0);
   assign full  = (count == LVL_W'(DEPTH));

endmodule

// File: rtl/ft245_sync_tx.sv
// FT245 synchronous-FIFO transmit stage: upstream valid/ready into a byte FIFO, then WR#/D[7:0].
// Define FT245_SEND_IMMEDIATE_EN to add the idle-triggered SIWU# flush pulse.
module ft245_sync_tx
   import ft245_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = FT245_DEF_DEPTH,
   parameter int unsigned SI_IDLE_CYCLES = FT245_DEF_SI_IDLE
) (
   input  logic                         clock_60mhz,
   input  logic                         reset,
   input  logic [FT245_BYTE_W-1:0]      in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [$clog2(FIFO_DEPTH):0]  level,
   output logic [FT245_BYTE_W-1:0]      data,
   input  logic                         tx_full,
   output logic                         write_n,
   output logic                         read_n,
   output logic                         output_enable_n,
   output logic                         send_immediately_n,
   output logic                         tx_active_led_n
);

   logic                    fifo_empty;
   logic                    fifo_full;
   logic                    push;
   logic                    load;
   logic                    flush_q;
   logic [FT245_BYTE_W-1:0] head;
   ft245_state_t            state;

   assign in_ready = !fifo_full;
   assign push     = in_valid && in_ready;
   assign state    = ft245_state(write_n, tx_full, flush_q);

   // The output register only reloads when nothing is presented or the presented byte is accepted.
   always_comb begin
      load = 1'b0;
      case (state)
         ST_IDLE, ST_SEND: load = !fifo_empty;
         default:          load = 1'b0;
      endcase
   end

   ft245_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clock_60mhz),
      .rst       (reset),
      .push      (push),
      .push_data (in_data),
      .pop       (load),
      .head      (head),
      .level     (level),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   always_ff @(posedge clock_60mhz or posedge reset) begin
      if (reset) begin
         data    <= '0;
         write_n <= 1'b1;
      end else begin
         case (state)
            ST_IDLE, ST_SEND: begin
               if (load) begin
                  data    <= head;
                  write_n <= 1'b0;
               end else begin
                  write_n <= 1'b1;
               end
            end
            default: begin
               data    <= data;
               write_n <= write_n;
            end
         endcase
      end
   end

`ifdef FT245_SEND_IMMEDIATE_EN
   localparam int unsigned CNT_W = (SI_IDLE_CYCLES > 1) ? $clog2(SI_IDLE_CYCLES) : 1;

   logic             armed_q;
   logic [CNT_W-1:0] idle_cnt;

   // Armed by any accepted byte; fires after SI_IDLE_CYCLES idle-and-empty cycles, then disarms.
   always_ff @(posedge clock_60mhz or posedge reset) begin
      if (reset) begin
         flush_q  <= 1'b0;
         armed_q  <= 1'b0;
         idle_cnt <= '0;
      end else begin
         flush_q <= 1'b0;
         if (state == ST_SEND) armed_q <= 1'b1;
         if (flush_q) begin
            idle_cnt <= '0;
         end else if (armed_q && (state == ST_IDLE) && fifo_empty) begin
            if (idle_cnt == CNT_W'(SI_IDLE_CYCLES - 1)) begin
               flush_q  <= 1'b1;
               armed_q  <= 1'b0;
               idle_cnt <= '0;
            end else begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end else begin
            idle_cnt <= '0;
         end
      end
   end

   assign send_immediately_n = !flush_q;
`else
   assign flush_q            = 1'b0;
   assign send_immediately_n = 1'b1;
`endif

   assign read_n          = 1'b1;
   assign output_enable_n = 1'b1;
   assign tx_active_led_n = write_n;

endmodule

// File: tb/tb_ft245_sync_tx.sv
// Self-checking bench for ft245_sync_tx: vector table, FT245 receiver scoreboard and corner sequences.
// Also covers the SIWU# pulse when built with FT245_SEND_IMMEDIATE_EN.
module tb_ft245_sync_tx;

   localparam int DEPTH = 16;
   localparam int SI    = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] level;
   logic [7:0] data;
   logic       tx_full;
   logic       write_n;
   logic       read_n;
   logic       oe_n;
   logic       si_n;
   logic       led;

   int n_cmp = 0;
   int n_bad = 0;
   int gcyc  = 0;

   // Receiver-side expectation model.
   int         mlevel;
   bit         mwn;
   bit         mflush;
   bit         marmed;
   int         mcnt;
   logic [7:0] q[$];

   ft245_sync_tx #(
      .FIFO_DEPTH     (DEPTH),
      .SI_IDLE_CYCLES (SI)
   ) dut (
      .clock_60mhz        (clk),
      .reset              (rst),
      .in_data            (in_data),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .level              (level),
      .data               (data),
      .tx_full            (tx_full),
      .write_n            (write_n),
      .read_n             (read_n),
      .output_enable_n    (oe_n),
      .send_immediately_n (si_n),
      .tx_active_led_n    (led)
   );

   always #8 clk = ~clk;

   always @(posedge clk) gcyc <= gcyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Monitor: compares outputs against the model at each falling edge, then advances the model
   // to what the coming rising edge must do.
   always @(negedge clk) begin
      bit adv, psh, pp, acc;
      if (rst) begin
         mlevel = 0; mwn = 1'b1; mflush = 1'b0; marmed = 1'b0; mcnt = 0;
         q.delete();
         chk("rst_write_n", write_n, 1);
         chk("rst_data", data, 0);
         chk("rst_level", level, 0);
         chk("rst_in_ready", in_ready, 1);
         chk("rst_si_n", si_n, 1);
         chk("rst_led", led, 1);
         chk("rst_read_n", read_n, 1);
         chk("rst_oe_n", oe_n, 1);
      end else begin
         chk("write_n", write_n, mwn);
         chk("level", level, mlevel);
         chk("in_ready", in_ready, mlevel != DEPTH);
         chk("led", led, mwn);
         chk("read_n", read_n, 1);
         chk("oe_n", oe_n, 1);
         chk("si_n", si_n, !mflush);
         chk("level_max", level <= DEPTH, 1);
         if (!mwn) begin
            if (q.size() == 0) chk("sb_underflow", 1, 0);
            else               chk("data", data, q[0]);
         end
         adv = (mwn || !tx_full) && !mflush;
         psh = in_valid && (mlevel != DEPTH);
         pp  = adv && (mlevel != 0);
         acc = !mwn && !tx_full;
         if (acc && q.size() > 0) void'(q.pop_front());
`ifdef FT245_SEND_IMMEDIATE_EN
         if (mflush) begin
            mflush = 1'b0;
            mcnt   = 0;
         end else if (marmed && mwn && mlevel == 0) begin
            mcnt++;
            if (mcnt == SI) begin
               mflush = 1'b1;
               marmed = 1'b0;
               mcnt   = 0;
            end
         end else begin
            mcnt = 0;
         end
         if (acc) marmed = 1'b1;
`endif
         if (psh) q.push_back(in_data);
         if (adv) mwn = (mlevel == 0);
         mlevel = mlevel + int'(psh) - int'(pp);
      end
   end

   // Push n bytes base, base+1, ... ; mode 0: TXE# low, 1: high 3 of every 7, 2: random, 3: held high.
   task automatic stream(input int n, input logic [7:0] base, input int mode, input bit rnd,
                         input int budget, output int taken);
      int  cyc;
      bit  hs;
      taken = 0;
      cyc   = 0;
      while (taken < n && cyc < budget) begin
         case (mode)
            0:       tx_full = 1'b0;
            1:       tx_full = (gcyc % 7) < 3;
            2:       tx_full = ($urandom_range(0, 2) == 0);
            default: tx_full = 1'b1;
         endcase
         in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = base + 8'(taken);
         @(negedge clk);
         hs = in_valid && in_ready;
         @(posedge clk);
         #2;
         if (hs) taken++;
         cyc++;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int  c;
      bit  done;
      tx_full = 1'b0;
      done    = 1'b0;
      for (c = 0; c < budget; c++) begin
         if (q.size() == 0 && write_n && level == 0) begin
            done = 1'b1;
            break;
         end
         tick(1);
      end
      chk("drain_done", done, 1);
   endtask

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       txf;
      logic       exp_wn;
      logic [4:0] exp_lvl;
      logic [7:0] exp_data;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int taken;
      int run;
      int first_c;
      int lows;

      // Expected state is what the DUT shows while that row's inputs are applied.
      tbl[0] = '{1'b1, 8'hA0, 1'b0, 1'b1, 5'd0, 8'h00};
      tbl[1] = '{1'b1, 8'hA1, 1'b0, 1'b1, 5'd1, 8'h00};
      tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 8'hA0};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'hA1};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'hA1};
      tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'hA1};
      tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 8'h00};
      tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 8'h00};

      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      tx_full  = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(1);

      for (int k = 0; k < 8; k++) begin
         in_valid = tbl[k].v;
         in_data  = tbl[k].d;
         tx_full  = tbl[k].txf;
         @(negedge clk);
         chk($sformatf("tbl%0d_write_n", k), write_n, tbl[k].exp_wn);
         chk($sformatf("tbl%0d_level", k), level, tbl[k].exp_lvl);
         chk($sformatf("tbl%0d_in_ready", k), in_ready, 1);
         if (!tbl[k].exp_wn) chk($sformatf("tbl%0d_data", k), data, tbl[k].exp_data);
         @(posedge clk);
         #2;
      end
      drain(20);

      // 0x00..0x0F back to back: first WR# low two edges after the first push, then 16 accepts.
      run     = 0;
      first_c = -1;
      tx_full = 1'b0;
      fork
         begin
            for (int i = 0; i < 16; i++) begin
               in_valid = 1'b1;
               in_data  = 8'(i);
               tick(1);
            end
            in_valid = 1'b0;
         end
         begin
            for (int c = 0; c < 60; c++) begin
               @(negedge clk);
               if (!write_n && !tx_full) begin
                  if (first_c < 0) first_c = c;
                  run++;
               end else if (run > 0) begin
                  break;
               end
            end
         end
      join
      tick(1);
      chk("seq16_first_present", first_c, 2);
      chk("seq16_run", run, 16);
      drain(40);

      // Periodic TXE# stalls.
      stream(40, 8'h20, 1, 1'b0, 400, taken);
      chk("toggle_taken", taken, 40);
      drain(100);

      // TXE# held high: FIFO fills to DEPTH with one more byte parked in the output register.
      tx_full = 1'b1;
      stream(20, 8'h80, 3, 1'b0, 30, taken);
      @(negedge clk);
      chk("fill_taken", taken, 17);
      chk("fill_level", level, 16);
      chk("fill_in_ready", in_ready, 0);
      chk("fill_write_n", write_n, 0);
      chk("fill_data", data, 8'h80);
      @(posedge clk);
      #2;
      stream(3, 8'h91, 0, 1'b0, 40, taken);
      chk("fill_rest_taken", taken, 3);
      drain(100);

      // Reset while 0x5A is stalled on the bus.
      tx_full  = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h5A;
      tick(1);
      in_valid = 1'b0;
      tick(3);
      chk("stall_write_n", write_n, 0);
      chk("stall_data", data, 8'h5A);
      rst = 1'b1;
      #1;
      chk("midrst_write_n", write_n, 1);
      chk("midrst_data", data, 0);
      chk("midrst_level", level, 0);
      chk("midrst_in_ready", in_ready, 1);
      tick(2);
      rst     = 1'b0;
      tx_full = 1'b0;
      tick(1);
      stream(8, 8'h60, 0, 1'b0, 40, taken);
      chk("post_rst_taken", taken, 8);
      drain(40);

      // Random valid and TXE#, enough bytes to wrap the pointers several times.
      stream(100, 8'hC0, 2, 1'b1, 2000, taken);
      chk("random_taken", taken, 100);
      drain(200);

`ifdef FT245_SEND_IMMEDIATE_EN
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      lows = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (!si_n) lows++;
      end
      chk("si_no_early_pulse", lows, 0);
      @(posedge clk);
      #2;
      in_valid = 1'b1;
      in_data  = 8'h3C;
      tick(1);
      in_valid = 1'b0;
      first_c  = -1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!write_n) begin
            first_c = c;
            break;
         end
      end
      chk("si_byte_presented", first_c >= 0, 1);
      run = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (si_n) run++;
         else break;
      end
      chk("si_delay", run, SI);
      chk("si_low", si_n, 0);
      @(negedge clk);
      chk("si_width", si_n, 1);
      @(posedge clk);
      #2;
`endif

      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      n_bad++;
      $display("FAIL watchdog: got timeout, expected test completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule
